// File: rtl/sync_filter.sv
// sync_filter: WIDTH-channel asynchronous input synchroniser with a per-channel
// stability filter and registered single-cycle rise/fall pulses.
module sync_filter #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      DEPTH     = 2,
    parameter int unsigned      FILTER    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sig_in,
    input  logic             hold,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned   CW     = (FILTER == 0) ? 1 : $clog2(FILTER + 1);
    localparam logic [CW-1:0] FILT_C = CW'(FILTER);

    logic [WIDTH-1:0] rise_d, fall_d;
    logic [WIDTH-1:0] rise_q, fall_q;
    logic             changed_d, changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        (* preserve *) logic [DEPTH-1:0] chain_q;
        logic [DEPTH-1:0] chain_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic             out_q, out_d;
        logic             accept;
        logic             s;

        assign s = chain_q[DEPTH-1];

        // Synchroniser chain: shift the raw input in every edge, hold has no effect.
        always_comb begin
            chain_d = {chain_q[DEPTH-2:0], sig_in[i]};
        end

        // Synchroniser chain register.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                chain_q <= {DEPTH{RESET_VAL[i]}};
            end else begin
                chain_q <= chain_d;
            end
        end

        // Stability filter: accept s once it has differed for FILTER+1 sampling edges.
        always_comb begin
            cnt_d  = cnt_q;
            out_d  = out_q;
            accept = 1'b0;
            if (!hold) begin
                if (s == out_q) begin
                    cnt_d = '0;
                end else if (cnt_q == FILT_C) begin
                    out_d  = s;
                    cnt_d  = '0;
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        // Filter state register.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                out_q <= RESET_VAL[i];
            end else begin
                cnt_q <= cnt_d;
                out_q <= out_d;
            end
        end

        assign rise_d[i]  = accept & s;
        assign fall_d[i]  = accept & ~s;
        assign sig_out[i] = out_q;
    end

    // Summary flag for the pulses being registered this edge.
    always_comb begin
        changed_d = |(rise_d | fall_d);
    end

    // Pulse registers, aligned with the sig_out update.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: two instances (DEPTH=2/FILTER=4 and
// DEPTH=3/FILTER=0) share stimulus and are compared every cycle against a
// behavioural model built from input history and qualification run lengths.
module tb_sync_filter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sig_in = '0;
    logic       hold = 1'b0;

    logic [3:0] so0, r0, f0;
    logic       c0;
    logic [3:0] so1, r1, f1;
    logic       c1;

    int checks = 0;
    int errors = 0;

    sync_filter #(.WIDTH(4), .DEPTH(2), .FILTER(4), .RESET_VAL(4'b0000)) u0 (
        .clock(clock), .reset_n(reset_n), .sig_in(sig_in), .hold(hold),
        .sig_out(so0), .rise(r0), .fall(f0), .changed(c0)
    );

    sync_filter #(.WIDTH(4), .DEPTH(3), .FILTER(0), .RESET_VAL(4'b0000)) u1 (
        .clock(clock), .reset_n(reset_n), .sig_in(sig_in), .hold(hold),
        .sig_out(so1), .rise(r1), .fall(f1), .changed(c1)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    logic [3:0] hq0[$];
    logic [3:0] hq1[$];
    logic [3:0] m_out[2];
    logic [3:0] m_rise[2];
    logic [3:0] m_fall[2];
    int         m_run[2][4];

    task automatic model_reset();
        hq0.delete();
        hq1.delete();
        for (int m = 0; m < 2; m++) begin
            m_out[m]  = '0;
            m_rise[m] = '0;
            m_fall[m] = '0;
            for (int c = 0; c < 4; c++) m_run[m][c] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] s;
        int         filt;
        for (int m = 0; m < 2; m++) begin
            // synchronised level = input sampled DEPTH edges ago (reset level before that)
            s = '0;
            if (m == 0) begin
                if (hq0.size() >= 2) s = hq0[hq0.size() - 2];
            end else begin
                if (hq1.size() >= 3) s = hq1[hq1.size() - 3];
            end
            filt      = (m == 0) ? 4 : 0;
            m_rise[m] = '0;
            m_fall[m] = '0;
            if (!hold) begin
                for (int c = 0; c < 4; c++) begin
                    if (s[c] == m_out[m][c]) begin
                        m_run[m][c] = 0;
                    end else if (m_run[m][c] == filt) begin
                        m_out[m][c] = s[c];
                        if (s[c]) m_rise[m][c] = 1'b1;
                        else      m_fall[m][c] = 1'b1;
                        m_run[m][c] = 0;
                    end else begin
                        m_run[m][c] = m_run[m][c] + 1;
                    end
                end
            end
        end
        hq0.push_back(sig_in);
        hq1.push_back(sig_in);
        if (hq0.size() > 8) void'(hq0.pop_front());
        if (hq1.size() > 8) void'(hq1.pop_front());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("u0.sig_out", 32'(so0), 32'(m_out[0]));
        chk("u0.rise",    32'(r0),  32'(m_rise[0]));
        chk("u0.fall",    32'(f0),  32'(m_fall[0]));
        chk("u0.changed", 32'(c0),  32'(|(m_rise[0] | m_fall[0])));
        chk("u1.sig_out", 32'(so1), 32'(m_out[1]));
        chk("u1.rise",    32'(r1),  32'(m_rise[1]));
        chk("u1.fall",    32'(f1),  32'(m_fall[1]));
        chk("u1.changed", 32'(c1),  32'(|(m_rise[1] | m_fall[1])));
    endtask

    // Model update and comparison after every edge and every reset assertion.
    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
            #1;
            compare_all();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus and literal expectations ----------------
    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset: all outputs low during and after
        edges(3);
        chk("rst.sig_out", 32'(so0), 0);
        chk("rst.pulses",  32'({r0, f0, c0}), 0);
        reset_n = 1'b1;
        chk("post_rst.sig_out", 32'(so0), 0);

        // Single rise on ch0: accepted after edge 7
        sig_in = 4'b0001;
        edges(6);
        chk("lat.before", 32'(so0), 0);
        edges(1);
        chk("lat.sig_out", 32'(so0), 32'h1);
        chk("lat.rise",    32'(r0),  32'h1);
        chk("lat.changed", 32'(c0),  1);
        edges(1);
        chk("lat.rise_clr", 32'(r0), 0);

        // 4-cycle glitch on ch1 is rejected
        sig_in = 4'b0011;
        edges(4);
        sig_in = 4'b0001;
        edges(10);
        chk("glitch4.sig_out", 32'(so0), 32'h1);

        // 5-cycle pulse on ch1 is accepted; fall 5 cycles after rise
        sig_in = 4'b0011;
        edges(5);
        sig_in = 4'b0001;
        edges(2);
        chk("pulse5.rise",    32'(r0),  32'h2);
        chk("pulse5.sig_out", 32'(so0), 32'h3);
        edges(5);
        chk("pulse5.fall",    32'(f0),  32'h2);
        chk("pulse5.sig_out2", 32'(so0), 32'h1);

        // Simultaneous changes
        sig_in = 4'b0000;
        edges(10);
        sig_in = 4'b1010;
        edges(7);
        chk("simul.rise",    32'(r0), 32'ha);
        chk("simul.fall",    32'(f0), 0);
        chk("simul.changed", 32'(c0), 1);

        // Hold two counts into a qualification for 10 cycles
        sig_in = 4'b1110;
        edges(4);
        hold = 1'b1;
        edges(10);
        chk("hold.frozen", 32'(so0), 32'ha);
        hold = 1'b0;
        edges(2);
        chk("hold.remain", 32'(so0), 32'ha);
        edges(1);
        chk("hold.accept", 32'(so0), 32'he);
        chk("hold.rise",   32'(r0),  32'h4);

        // Reset mid-qualification (cnt[2]=3), input high at release
        sig_in = 4'b1010;
        edges(5);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst.sig_out", 32'(so0), 0);
        chk("midrst.pulses",  32'({r0, f0, c0}), 0);
        sig_in = 4'b0100;
        edges(2);
        #2 reset_n = 1'b1;
        edges(6);
        chk("relrst.before",  32'(so0), 0);
        edges(1);
        chk("relrst.sig_out", 32'(so0), 32'h4);
        chk("relrst.rise",    32'(r0),  32'h4);

        // DEPTH=3/FILTER=0 instance following a period-2 toggle on ch3
        sig_in = 4'b0000;
        edges(10);
        for (int k = 1; k <= 8; k++) begin
            sig_in = (k % 2 == 1) ? 4'b1000 : 4'b0000;
            edges(1);
            chk("tog.sig_out", 32'(so1[3]), 32'((k >= 4) && (k % 2 == 0)));
            chk("tog.rise",    32'(r1[3]),  32'((k >= 4) && (k % 2 == 0)));
            chk("tog.fall",    32'(f1[3]),  32'((k >= 5) && (k % 2 == 1)));
        end
        sig_in = 4'b0000;
        edges(6);

        // Randomised traffic with occasional hold and asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5 + 2 * c) == 0) sig_in[c] = ~sig_in[c];
            end
            hold = ($urandom_range(0, 9) == 0);
            edges(1);
            if ($urandom_range(0, 399) == 0) begin
                #2 reset_n = 1'b0;
                edges(1);
                #2 reset_n = 1'b1;
            end
        end
        hold = 1'b0;
        edges(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_filter.md
# sync_filter

Multi-channel, parametrised successor to the single-bit two-flop synchroniser. It brings WIDTH independent asynchronous inputs into the `clock` domain through a DEPTH-stage chain per channel. A per-channel stability filter then rejects glitches shorter than a programmed length, and the block emits registered single-cycle rise/fall pulses. It is used for front-panel keys, PTT and CW key lines, and slow status lines entering the ethernet/control logic.

## Interface
- WIDTH, 4: number of independent channels (≥1).
- DEPTH, 2: synchroniser stages per channel (≥2).
- FILTER, 4: extra consecutive cycles a new synchronised level must persist before it is accepted. 0 means no filtering. Range 0..255.
- RESET_VAL, {WIDTH{1'b0}}: per-channel reset level for the chain, `sig_out` and the filter state.

- clock  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- sig_in  in  WIDTH  asynchronous inputs
- hold  in  1  synchronous freeze of filter, outputs and pulses
- sig_out  out  WIDTH  filtered, synchronised level
- rise  out  WIDTH  one-cycle pulse per channel on an accepted 0→1 change
- fall  out  WIDTH  one-cycle pulse per channel on an accepted 1→0 change
- changed  out  1  registered OR of all rise and fall bits from the same edge

## Operation
- Per channel i, the chain shifts `sig_in[i]` in on every edge. `s[i]` is the last stage. The chain keeps running regardless of `hold`. Chain registers carry the preserve attribute.
- Per channel filter counter `cnt[i]`:
  - Width is max(1, clog2(FILTER+1)).
  - Resets to 0.
- Each edge with hold=0:
  - If s[i]==sig_out[i]: cnt[i]←0 and no pulse.
  - If s[i]!=sig_out[i] and cnt[i]==FILTER: sig_out[i]←s[i], cnt[i]←0, and rise[i] or fall[i] asserts for one cycle according to s[i].
  - Otherwise: cnt[i]←cnt[i]+1.
- Each edge with hold=1:
  - cnt and sig_out hold their values.
  - rise, fall and changed are 0.
  - When hold drops, filtering resumes from the held count.
- rise and fall are 0 on every edge where the acceptance condition is not met, so each is never high for two consecutive cycles from one change.
- changed is registered alongside rise and fall and equals |(rise|fall) of the same cycle.
- Channels are fully independent. Simultaneous acceptances on several channels assert all the corresponding pulse bits in the same cycle.
- A level that returns to sig_out before the count completes clears cnt. A later change must restart the full qualification.
- Reset values:
  - sync chain, sig_out and filter state: RESET_VAL per channel.
  - cnt: 0.
  - rise, fall, changed: 0.
- Reset assertion mid-qualification discards the count immediately. No pulse is emitted on reset assertion.
- After reset release, an input that differs from RESET_VAL is treated as a normal change. It is accepted with the standard latency and does produce a rise/fall pulse.

## Timing
- Latency: sig_in stable before edge 1 gives s[i] valid after edge DEPTH. sig_out[i] and the pulse appear after edge DEPTH+FILTER+1, for a total of DEPTH+FILTER+1 cycles.
- Acceptance threshold:
  - A synchronised excursion is accepted only if s[i] differs from sig_out[i] on FILTER+1 consecutive sampling edges.
  - FILTER or fewer consecutive edges are rejected, with no change on sig_out and no pulse.
- Pulse alignment: rise[i]/fall[i] are high in exactly the cycle in which sig_out[i] first shows the new level.
- FILTER=0: sig_out is s delayed by one register, with a pulse on every change of s.
- The minimum spacing between accepted changes on one channel is FILTER+1 cycles.
- hold is sampled synchronously. An acceptance due on an edge where hold=1 is postponed to the first edge with hold=0.

## Test plan
- Reset with WIDTH=4, DEPTH=2, FILTER=4, RESET_VAL=4'b0000 and sig_in=0:
  - All outputs are 0 during and after reset.
  - Raise sig_in[0] before edge 1 → sig_out[0]=1 with rise[0]=1 and changed=1 after edge 7, and rise[0]=0 after edge 8.
- Glitch rejection with FILTER=4:
  - A 4-cycle-wide high pulse on sig_in[1] gives no change on sig_out[1] and no pulse.
  - A 5-cycle pulse gives rise[1] 7 cycles after the rising input, then fall[1] 5 cycles after the rise.
- Simultaneous events: sig_in 0000→1010 in one cycle → rise=1010 and changed=1 on the same cycle, with fall=0000.
- Hold:
  - Assert hold 2 cycles into a qualifying change and keep it for 10 cycles → sig_out stays frozen and there are no pulses.
  - After release, acceptance occurs after the remaining count of 3 edges.
- Reset mid-operation:
  - Assert reset_n=0 while cnt[2]=3 → all outputs return to RESET_VAL and 0 asynchronously.
  - With sig_in[2]=1 at release, sig_out[2] rises with a rise[2] pulse 7 cycles after release.
- FILTER=0 and DEPTH=3: a toggling sig_in[3] at period 2 cycles → sig_out[3] follows with 4-cycle latency and alternates rise/fall every cycle.
